// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, iterative-unit state encoding and
// opcode classification used by the ALU, the decoder and the hazard unit.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_BEQ   = 4'b0101;
  localparam logic [3:0] ALU_BNE   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_MUL   = 4'b1011;
  localparam logic [3:0] ALU_MULHU = 4'b1100;
  localparam logic [3:0] ALU_DIVU  = 4'b1101;
  localparam logic [3:0] ALU_REMU  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per
// cycle for WIDTH cycles; exposes the next-step values so the top can register them.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo_next,
  output logic [WIDTH-1:0] o_hi_next
);

  localparam int CW = $clog2(WIDTH);

  // mul: r_op = multiplicand, {r_hi,r_lo} = partial product / multiplier
  // div: r_op = divisor, r_hi = remainder, r_lo = dividend shifting into quotient
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
    w_trial = {r_hi, r_lo[WIDTH-1]};
    w_ge    = w_trial >= {1'b0, r_op};
    w_diff  = w_trial - {1'b0, r_op};
    if (i_is_div) begin
      o_hi_next = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
      o_lo_next = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      o_hi_next = w_sum[WIDTH:1];
      o_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_done = r_busy && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_op   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_hi   <= '0;
      r_lo   <= i_is_div ? i_a : i_b;
      r_op   <= i_is_div ? i_b : i_a;
      r_cnt  <= CW'(WIDTH - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_hi  <= o_hi_next;
      r_lo  <= o_lo_next;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU: single-cycle ops complete at the issue edge,
// MUL/MULHU/DIVU/REMU run WIDTH cycles in alu_muldiv_iter behind in_ready.
module alu_pipe #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       aluop,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             gt,
  output logic             bcond
);

  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  alu_state_t       r_state;
  alu_state_t       w_state_next;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_lt;
  logic             r_gt;
  logic             r_bcond;
  logic             r_pend_lt;
  logic             r_pend_gt;
  logic             r_sel_hi;

  logic             w_is_md;
  logic             w_op_div;
  logic             w_start;
  logic             w_is_div;
  logic             w_done;
  logic [WIDTH-1:0] w_lo_next;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_bcond;
  logic             w_lt;
  logic             w_gt;
  logic             w_eq;
  logic [CW-1:0]    w_sh;

  assign w_is_md  = MULDIV_EN && is_muldiv(aluop);
  assign w_op_div = (aluop == ALU_DIVU) || (aluop == ALU_REMU);
  assign w_lt     = data1 < data2;
  assign w_gt     = data1 > data2;
  assign w_eq     = data1 == data2;
  assign w_sh     = data2[CW-1:0];
  // The divider must know its mode on the load edge too, before the state says DIV.
  assign w_is_div = (r_state == ST_IDLE) ? w_op_div : (r_state == ST_DIV);

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && w_is_md) begin
          w_start      = 1'b1;
          w_state_next = w_op_div ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (flush) begin
      w_state_next = ST_IDLE;
      w_start      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_sc_res   = data1 + data2;
    w_sc_bcond = 1'b0;
    case (aluop)
      ALU_SUB:  w_sc_res = data1 - data2;
      ALU_AND:  w_sc_res = data1 & data2;
      ALU_OR:   w_sc_res = data1 | data2;
      ALU_XOR:  w_sc_res = data1 ^ data2;
      ALU_BEQ: begin
        w_sc_res   = data1 - data2;
        w_sc_bcond = w_eq;
      end
      ALU_BNE: begin
        w_sc_res   = data1 - data2;
        w_sc_bcond = !w_eq;
      end
      ALU_SLTU: begin
        w_sc_res    = '0;
        w_sc_res[0] = w_lt;
      end
      ALU_SLL:  w_sc_res = data1 << w_sh;
      ALU_SRL:  w_sc_res = data1 >> w_sh;
      ALU_SRA:  w_sc_res = WIDTH'($signed(data1) >>> w_sh);
      default:  w_sc_res = data1 + data2;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .i_start   (w_start),
    .i_is_div  (w_is_div),
    .i_a       (data1),
    .i_b       (data2),
    .o_done    (w_done),
    .o_lo_next (w_lo_next),
    .o_hi_next (w_hi_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_lt      <= 1'b0;
      r_gt      <= 1'b0;
      r_bcond   <= 1'b0;
      r_pend_lt <= 1'b0;
      r_pend_gt <= 1'b0;
      r_sel_hi  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (flush) begin
        r_valid <= 1'b0;
      end else if (r_state == ST_IDLE && in_valid) begin
        if (w_is_md) begin
          // Flags are sampled at issue but published together with the result.
          r_pend_lt <= w_lt;
          r_pend_gt <= w_gt;
          r_sel_hi  <= (aluop == ALU_MULHU) || (aluop == ALU_REMU);
        end else begin
          r_result <= w_sc_res;
          r_lt     <= w_lt;
          r_gt     <= w_gt;
          r_bcond  <= w_sc_bcond;
          r_valid  <= 1'b1;
        end
      end else if (r_state != ST_IDLE && w_done) begin
        r_result <= r_sel_hi ? w_hi_next : w_lo_next;
        r_lt     <= r_pend_lt;
        r_gt     <= r_pend_gt;
        r_bcond  <= 1'b0;
        r_valid  <= 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_valid;
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign lt        = r_lt;
  assign gt        = r_gt;
  assign bcond     = r_bcond;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: three instances (32-bit, 8-bit, 32-bit without mul/div)
// share stimulus; a per-instance behavioural model predicts every cycle.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  aluop;

  logic        rdy[3];
  logic        ov[3];
  logic        zr[3];
  logic        lto[3];
  logic        gto[3];
  logic        bco[3];
  logic [31:0] res_o[3];
  logic [31:0] res0;
  logic [31:0] res2;
  logic [7:0]  res8;

  int checks = 0;
  int errors = 0;
  int n = 0;

  bit          pend[3];
  int          pdue[3];
  int          busy[3];
  logic [31:0] p_res[3];
  bit          p_lt[3], p_gt[3], p_bc[3];
  logic [31:0] e_res[3];
  bit          e_lt[3], e_gt[3], e_bc[3];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .MULDIV_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .data1(data1), .data2(data2), .aluop(aluop), .out_valid(ov[0]), .result(res0),
    .zero(zr[0]), .lt(lto[0]), .gt(gto[0]), .bcond(bco[0]));

  alu_pipe #(.WIDTH(8), .MULDIV_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .data1(data1[7:0]), .data2(data2[7:0]), .aluop(aluop), .out_valid(ov[1]), .result(res8),
    .zero(zr[1]), .lt(lto[1]), .gt(gto[1]), .bcond(bco[1]));

  alu_pipe #(.WIDTH(32), .MULDIV_EN(1'b0)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
    .data1(data1), .data2(data2), .aluop(aluop), .out_valid(ov[2]), .result(res2),
    .zero(zr[2]), .lt(lto[2]), .gt(gto[2]), .bcond(bco[2]));

  assign res_o[0] = res0;
  assign res_o[1] = {24'h0, res8};
  assign res_o[2] = res2;

  function automatic int wid(input int d);
    return (d == 1) ? 8 : 32;
  endfunction

  function automatic bit mden(input int d);
    return d != 2;
  endfunction

  // Reference arithmetic on plain integers, masked to w bits.
  function automatic longint unsigned mdl(input int op_in, input longint unsigned a,
                                          input longint unsigned b, input int w, input bit md);
    longint unsigned m;
    int sh;
    int op;
    longint unsigned v;
    m  = (64'd1 << w) - 64'd1;
    sh = int'(b % longint'(w));
    op = op_in;
    if (!md && op >= 11 && op <= 14) op = 0;
    case (op)
      1, 5, 6: return (a - b) & m;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      7:  return (a < b) ? 64'd1 : 64'd0;
      8:  return (a << sh) & m;
      9:  return a >> sh;
      10: begin
        v = a >> sh;
        if (((a >> (w - 1)) & 64'd1) == 64'd1) v = v | (m & ~(m >> sh));
        return v;
      end
      11: return (a * b) & m;
      12: return (a * b) >> w;
      13: return (b == 0) ? m : a / b;
      14: return (b == 0) ? a : a % b;
      default: return (a + b) & m;
    endcase
  endfunction

  task automatic cmp(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %h want %h", nm, d, $time, act, exp);
    end
  endtask

  task automatic cmp1(input string nm, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %b want %b", nm, d, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    n++;
    for (int d = 0; d < 3; d++) begin
      longint unsigned m, a, b;
      int w, op, lat;
      bit e_ov;
      w = wid(d);
      m = (64'd1 << w) - 64'd1;
      if (rst) begin
        pend[d]  = 1'b0;
        busy[d]  = 0;
        e_res[d] = '0;
        e_lt[d]  = 1'b0;
        e_gt[d]  = 1'b0;
        e_bc[d]  = 1'b0;
        cmp1("rst_out_valid", d, ov[d], 1'b0);
        cmp("rst_result", d, res_o[d], 32'h0);
        cmp1("rst_zero", d, zr[d], 1'b1);
        cmp1("rst_lt", d, lto[d], 1'b0);
        cmp1("rst_gt", d, gto[d], 1'b0);
        cmp1("rst_bcond", d, bco[d], 1'b0);
      end else begin
        e_ov = pend[d] && (pdue[d] == n);
        if (e_ov) begin
          e_res[d] = p_res[d];
          e_lt[d]  = p_lt[d];
          e_gt[d]  = p_gt[d];
          e_bc[d]  = p_bc[d];
          pend[d]  = 1'b0;
        end
        cmp1("out_valid", d, ov[d], e_ov);
        cmp1("in_ready", d, rdy[d], n >= busy[d]);
        cmp("result", d, res_o[d], e_res[d]);
        cmp1("zero", d, zr[d], e_res[d] == 32'h0);
        cmp1("lt", d, lto[d], e_lt[d]);
        cmp1("gt", d, gto[d], e_gt[d]);
        cmp1("bcond", d, bco[d], e_bc[d]);
        if (flush) begin
          pend[d] = 1'b0;
          busy[d] = n + 1;
        end else if (in_valid && n >= busy[d]) begin
          a  = 64'(data1) & m;
          b  = 64'(data2) & m;
          op = int'(aluop);
          p_res[d] = 32'(mdl(op, a, b, w, mden(d)));
          p_lt[d]  = a < b;
          p_gt[d]  = a > b;
          p_bc[d]  = (op == 5) ? (a == b) : (op == 6) ? (a != b) : 1'b0;
          lat      = (mden(d) && op >= 11 && op <= 14) ? w : 0;
          pend[d]  = 1'b1;
          pdue[d]  = n + 1 + lat;
          busy[d]  = n + 1 + lat;
        end
      end
    end
  end

  task automatic wait_all_ready();
    int t;
    t = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut0 t=%0t got busy want ready", $time);
    end
  endtask

  task automatic go(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_all_ready();
    in_valid = 1'b1;
    aluop    = op;
    data1    = a;
    data2    = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_all_ready();
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    data1 = '0; data2 = '0; aluop = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cmp1("ready_after_rst", 0, rdy[0], 1'b1);

    cmp("pin_mulhu", 0, 32'(mdl(12, 64'hFFFF_FFFF, 64'd2, 32, 1'b1)), 32'h1);
    cmp("pin_sra8", 1, 32'(mdl(10, 64'h80, 64'd3, 8, 1'b1)), 32'hF0);

    go(ALU_ADD, 32'd1, 32'd2);
    cmp1("add_ov", 0, ov[0], 1'b1);
    cmp("add_res", 0, res_o[0], 32'd3);
    cmp1("add_lt", 0, lto[0], 1'b1);
    cmp1("add_gt", 0, gto[0], 1'b0);
    cmp1("add_zero", 0, zr[0], 1'b0);
    go(ALU_SUB, 32'd5, 32'd5);
    cmp("sub_res", 0, res_o[0], 32'd0);
    cmp1("sub_zero", 0, zr[0], 1'b1);
    cmp1("sub_lt", 0, lto[0], 1'b0);
    cmp1("sub_gt", 0, gto[0], 1'b0);
    go(ALU_BEQ, 32'd7, 32'd7);
    cmp1("beq_bcond", 0, bco[0], 1'b1);
    cmp1("beq_zero", 0, zr[0], 1'b1);
    go(ALU_BNE, 32'd7, 32'd7);
    cmp1("bne_bcond", 0, bco[0], 1'b0);
    go(ALU_BEQ, 32'd7, 32'd7);
    go(ALU_AND, 32'd7, 32'd7);
    cmp1("and_bcond", 0, bco[0], 1'b0);
    go(ALU_SRA, 32'h8000_0000, 32'h21);
    cmp("sra_res", 0, res_o[0], 32'hC000_0000);
    go(ALU_SLL, 32'd1, 32'd31);
    cmp("sll_res", 0, res_o[0], 32'h8000_0000);
    go(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    cmp("sltu_res", 0, res_o[0], 32'd0);

    go(ALU_MUL, 32'hFFFF_FFFF, 32'd2);
    cmp1("mul_ov", 0, ov[0], 1'b1);
    cmp("mul_res", 0, res_o[0], 32'hFFFF_FFFE);
    cmp("mul8_res", 1, res_o[1], 32'hFE);
    cmp("mul_as_add", 2, res_o[2], 32'h1);
    go(ALU_MULHU, 32'hFFFF_FFFF, 32'd2);
    cmp("mulhu_res", 0, res_o[0], 32'h1);
    cmp("mulhu8_res", 1, res_o[1], 32'h1);
    go(ALU_DIVU, 32'd100, 32'd7);
    cmp("divu_res", 0, res_o[0], 32'd14);
    cmp("divu8_res", 1, res_o[1], 32'd14);
    cmp("divu_as_add", 2, res_o[2], 32'd107);
    go(ALU_REMU, 32'd100, 32'd7);
    cmp("remu_res", 0, res_o[0], 32'd2);
    go(ALU_DIVU, 32'h1234, 32'd0);
    cmp("divu0_res", 0, res_o[0], 32'hFFFF_FFFF);
    cmp("divu0_8_res", 1, res_o[1], 32'hFF);
    go(ALU_REMU, 32'd9, 32'd0);
    cmp("remu0_res", 0, res_o[0], 32'd9);

    // flush landing on iteration 10 of a divide
    wait_all_ready();
    in_valid = 1'b1; aluop = ALU_DIVU; data1 = 32'd1000; data2 = 32'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    cmp1("flush_ready", 0, rdy[0], 1'b1);
    cmp1("flush_no_ov", 0, ov[0], 1'b0);
    r = res_o[0];
    cmp("flush_result_held", 0, r, 32'd9);

    // asynchronous reset partway through a multiply
    wait_all_ready();
    in_valid = 1'b1; aluop = ALU_MUL; data1 = 32'd12345; data2 = 32'd678;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    cmp("midrst_result", 0, res_o[0], 32'd0);
    cmp1("midrst_zero", 0, zr[0], 1'b1);
    cmp1("midrst_ov", 0, ov[0], 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    cmp1("midrst_ready", 0, rdy[0], 1'b1);

    for (int i = 0; i < 2500; i++) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 49) == 0);
      aluop    = 4'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0: r = 32'h0;
          1: r = 32'hFFFF_FFFF;
          2: r = 32'($urandom_range(0, 15));
          default: r = $urandom;
        endcase
        if (k == 0) data1 = r;
        else        data2 = r;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
